controller_iram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 512x32 instruction RAM between the CPU instruction-fetch master (read-only) and the debug/loader master (read/write). It sits between the two Avalon-MM masters and the RAM's slave port. It grants one access per cycle, with round-robin fairness and a bounded debug lock. It also returns read data with fixed one-cycle latency to the requester that issued the read.

---
 rtl/controller_iram_arbiter.sv | 136 +++++++++++++
 tb/tb_controller_iram_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_iram_arbiter.sv
// Round-robin arbiter sharing the single-port instruction RAM between fetch and debug masters.
// One grant per cycle, a bounded debug lock, and read data returned with one cycle of latency.
module controller_iram_arbiter #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  // Instruction fetch master (read-only)
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_readdatavalid,
  // Debug / loader master
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic                d_lock,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  // RAM slave port
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_debugaccess,
  output logic                ram_clken,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [1:0] OwnNone = 2'd0;
  localparam logic [1:0] OwnI    = 2'd1;
  localparam logic [1:0] OwnD    = 2'd2;

  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

  localparam logic [7:0] LockCntMax = 8'(LOCK_MAX);

  logic [1:0] rd_owner_q, rd_owner_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;

  logic i_req, d_req;
  logic grant_i, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Grants are suppressed while reset is held so no access or read tracking starts.
  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    lock_cnt_d = lock_cnt_q;
    if (reset_n) begin
      if (i_req && d_req) begin
        if (d_lock) begin
          if (lock_cnt_q >= LockCntMax) begin
            grant_i = 1'b1;
          end else begin
            grant_d    = 1'b1;
            lock_cnt_d = lock_cnt_q + 8'd1;
          end
        end else if (last_grant_q == GrantD) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
    if (!i_req || !d_lock || grant_i) begin
      lock_cnt_d = 8'd0;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_i) begin
      last_grant_d = GrantI;
    end else if (grant_d) begin
      last_grant_d = GrantD;
    end
  end

  // A simultaneous d_read/d_write is a write, so it never claims read data.
  always_comb begin
    rd_owner_d = OwnNone;
    if (grant_i) begin
      rd_owner_d = OwnI;
    end else if (grant_d && !d_write) begin
      rd_owner_d = OwnD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_owner_q   <= OwnNone;
      last_grant_q <= GrantD;
      lock_cnt_q   <= 8'd0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_comb begin
    i_waitrequest   = !reset_n || (i_req && !grant_i);
    d_waitrequest   = !reset_n || (d_req && !grant_d);
    i_readdata      = ram_readdata;
    d_readdata      = ram_readdata;
    i_readdatavalid = reset_n && (rd_owner_q == OwnI);
    d_readdatavalid = reset_n && (rd_owner_q == OwnD);
  end

  always_comb begin
    ram_chipselect  = grant_i || grant_d;
    ram_clken       = reset_n;
    ram_write       = grant_d && d_write;
    ram_debugaccess = grant_d && d_write;
    ram_address     = grant_d ? d_address : i_address;
    ram_byteenable  = grant_d ? d_byteenable : '1;
    ram_writedata   = d_writedata;
  end

endmodule

// File: tb/tb_controller_iram_arbiter.sv
// Table-driven bench for controller_iram_arbiter with a behavioural 512x32 RAM behind it.
// LOCK_MAX is overridden to 4 so the lock starvation pattern is short.
module tb_controller_iram_arbiter;

  logic        clk;
  logic        reset_n;
  logic [8:0]  i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        i_readdatavalid;
  logic [8:0]  d_address;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic        d_lock;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        d_readdatavalid;
  logic [8:0]  ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic        ram_debugaccess;
  logic        ram_clken;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  int n_chk  = 0;
  int n_fail = 0;

  controller_iram_arbiter #(
    .ADDR_W  (9),
    .DATA_W  (32),
    .LOCK_MAX(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_address      (i_address),
    .i_read         (i_read),
    .i_waitrequest  (i_waitrequest),
    .i_readdata     (i_readdata),
    .i_readdatavalid(i_readdatavalid),
    .d_address      (d_address),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_byteenable   (d_byteenable),
    .d_writedata    (d_writedata),
    .d_lock         (d_lock),
    .d_waitrequest  (d_waitrequest),
    .d_readdata     (d_readdata),
    .d_readdatavalid(d_readdatavalid),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_debugaccess(ram_debugaccess),
    .ram_clken      (ram_clken),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_readdata   (ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m(int a);
    return 32'h1000_0000 + 32'(a) * 32'h0001_0001;
  endfunction

  logic [31:0] mem [512];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = m(i);
    ram_readdata = 32'h0;
  end

  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ir;
    logic [8:0]  ia;
    logic        dr;
    logic        dw;
    logic        dl;
    logic [8:0]  da;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        eiw;
    logic        edw;
    logic        ecs;
    logic        ewe;
    logic        eirv;
    logic        edrv;
    logic [8:0]  eaddr;
    logic [3:0]  ebe;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t v(logic ir, logic [8:0] ia, logic dr, logic dw, logic dl,
                             logic [8:0] da, logic [3:0] be, logic [31:0] wd,
                             logic eiw, logic edw, logic ecs, logic ewe,
                             logic eirv, logic edrv, logic [8:0] eaddr, logic [3:0] ebe,
                             logic [31:0] erd);
    vec_t r;
    r.ir = ir;   r.ia = ia;   r.dr = dr;     r.dw = dw;     r.dl = dl;
    r.da = da;   r.be = be;   r.wd = wd;
    r.eiw = eiw; r.edw = edw; r.ecs = ecs;   r.ewe = ewe;
    r.eirv = eirv; r.edrv = edrv; r.eaddr = eaddr; r.ebe = ebe; r.erd = erd;
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    // Round-robin contention from reset: I wins first tie.
    vecs.push_back(v(1, 3, 1, 0, 0, 5, 4'hF, 0, 0, 1, 1, 0, 0, 0, 3, 4'hF, 0));
    vecs.push_back(v(1, 3, 1, 0, 0, 5, 4'hF, 0, 1, 0, 1, 0, 1, 0, 5, 4'hF, m(3)));
    vecs.push_back(v(1, 3, 1, 0, 0, 6, 4'hF, 0, 0, 1, 1, 0, 0, 1, 3, 4'hF, m(5)));
    vecs.push_back(v(1, 0, 1, 0, 0, 6, 4'hF, 0, 1, 0, 1, 0, 1, 0, 6, 4'hF, m(3)));
    // Fetch-only streaming 0..7.
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 1, 0, 4'hF, m(6)));
    for (int k = 1; k < 8; k++)
      vecs.push_back(v(1, 9'(k), 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 1, 0, 9'(k), 4'hF, m(k-1)));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 4'h0, m(7)));
    // Partial write then fetch read of the same word.
    vecs.push_back(v(0, 0, 0, 1, 0, 9'h1F0, 4'h5, 32'hDEADBEEF,
                     0, 0, 1, 1, 0, 0, 9'h1F0, 4'h5, 0));
    vecs.push_back(v(1, 9'h1F0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 9'h1F0, 4'hF, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 4'h0, 32'h11AD01EF));
    // d_read and d_write together act as a write.
    vecs.push_back(v(0, 0, 1, 1, 0, 9'h10, 4'hF, 32'h12345678,
                     0, 0, 1, 1, 0, 0, 9'h10, 4'hF, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 9'h10, 4'hF, 0, 0, 0, 1, 0, 0, 0, 9'h10, 4'hF, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 32'h12345678));
    // Lock: D,D,D,D,I repeated with LOCK_MAX=4.
    vecs.push_back(v(1, 9'h20, 1, 0, 1, 9'h21, 4'hF, 0, 1, 0, 1, 0, 0, 0, 9'h21, 4'hF, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(v(1, 9'h20, 1, 0, 1, 9'h21, 4'hF, 0, 1, 0, 1, 0, 0, 1, 9'h21, 4'hF, m(9'h21)));
    vecs.push_back(v(1, 9'h20, 1, 0, 1, 9'h21, 4'hF, 0, 0, 1, 1, 0, 0, 1, 9'h20, 4'hF, m(9'h21)));
    vecs.push_back(v(1, 9'h20, 1, 0, 1, 9'h21, 4'hF, 0, 1, 0, 1, 0, 1, 0, 9'h21, 4'hF, m(9'h20)));
    for (int k = 0; k < 3; k++)
      vecs.push_back(v(1, 9'h20, 1, 0, 1, 9'h21, 4'hF, 0, 1, 0, 1, 0, 0, 1, 9'h21, 4'hF, m(9'h21)));
    vecs.push_back(v(1, 9'h20, 1, 0, 1, 9'h21, 4'hF, 0, 0, 1, 1, 0, 0, 1, 9'h20, 4'hF, m(9'h21)));
    // Lock dropped: alternation resumes from the last grant (I).
    vecs.push_back(v(1, 9'h20, 1, 0, 0, 9'h21, 4'hF, 0, 1, 0, 1, 0, 1, 0, 9'h21, 4'hF, m(9'h20)));
    vecs.push_back(v(1, 9'h20, 1, 0, 0, 9'h21, 4'hF, 0, 0, 1, 1, 0, 0, 1, 9'h20, 4'hF, m(9'h21)));
    vecs.push_back(v(1, 9'h20, 1, 0, 0, 9'h21, 4'hF, 0, 1, 0, 1, 0, 1, 0, 9'h21, 4'hF, m(9'h20)));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0, m(9'h21)));
  end

  initial begin
    reset_n      = 1'b0;
    i_read       = 1'b1;
    i_address    = 9'd3;
    d_read       = 1'b1;
    d_write      = 1'b0;
    d_address    = 9'd5;
    d_byteenable = 4'hF;
    d_writedata  = 32'h0;
    d_lock       = 1'b0;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst i_wait", 32'(i_waitrequest), 32'd1);
      check("rst d_wait", 32'(d_waitrequest), 32'd1);
      check("rst cs", 32'(ram_chipselect), 32'd0);
      check("rst we", 32'(ram_write), 32'd0);
      check("rst dbg", 32'(ram_debugaccess), 32'd0);
      check("rst clken", 32'(ram_clken), 32'd0);
      check("rst i_rv", 32'(i_readdatavalid), 32'd0);
      check("rst d_rv", 32'(d_readdatavalid), 32'd0);
    end

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk);
      #1;
      reset_n      = 1'b1;
      i_read       = vecs[k].ir;
      i_address    = vecs[k].ia;
      d_read       = vecs[k].dr;
      d_write      = vecs[k].dw;
      d_lock       = vecs[k].dl;
      d_address    = vecs[k].da;
      d_byteenable = vecs[k].be;
      d_writedata  = vecs[k].wd;
      @(negedge clk);
      check($sformatf("v%0d i_wait", k), 32'(i_waitrequest), 32'(vecs[k].eiw));
      check($sformatf("v%0d d_wait", k), 32'(d_waitrequest), 32'(vecs[k].edw));
      check($sformatf("v%0d cs", k), 32'(ram_chipselect), 32'(vecs[k].ecs));
      check($sformatf("v%0d we", k), 32'(ram_write), 32'(vecs[k].ewe));
      check($sformatf("v%0d dbg", k), 32'(ram_debugaccess), 32'(vecs[k].ewe));
      check($sformatf("v%0d clken", k), 32'(ram_clken), 32'd1);
      check($sformatf("v%0d i_rv", k), 32'(i_readdatavalid), 32'(vecs[k].eirv));
      check($sformatf("v%0d d_rv", k), 32'(d_readdatavalid), 32'(vecs[k].edrv));
      if (vecs[k].ecs) begin
        check($sformatf("v%0d addr", k), 32'(ram_address), 32'(vecs[k].eaddr));
        check($sformatf("v%0d be", k), 32'(ram_byteenable), 32'(vecs[k].ebe));
        if (vecs[k].ewe)
          check($sformatf("v%0d wdata", k), ram_writedata, vecs[k].wd);
      end
      if (vecs[k].eirv) check($sformatf("v%0d i_rdata", k), i_readdata, vecs[k].erd);
      if (vecs[k].edrv) check($sformatf("v%0d d_rdata", k), d_readdata, vecs[k].erd);
    end

    // Debug read granted, then reset before its data would be reported.
    @(posedge clk);
    #1;
    d_read    = 1'b1;
    d_address = 9'd5;
    @(negedge clk);
    check("mid d_wait", 32'(d_waitrequest), 32'd0);
    check("mid cs", 32'(ram_chipselect), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    d_read  = 1'b0;
    @(negedge clk);
    check("mid rst d_rv", 32'(d_readdatavalid), 32'd0);
    check("mid rst i_wait", 32'(i_waitrequest), 32'd1);
    check("mid rst d_wait", 32'(d_waitrequest), 32'd1);
    check("mid rst clken", 32'(ram_clken), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("post rst d_rv %0d", k), 32'(d_readdatavalid), 32'd0);
      check($sformatf("post rst i_rv %0d", k), 32'(i_readdatavalid), 32'd0);
      check($sformatf("post rst d_wait %0d", k), 32'(d_waitrequest), 32'd0);
      @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
